// File: rtl/riscv_muldiv_unit_if.sv
// rtl/riscv_muldiv_unit_if.sv - issue/result bundle between Execute and the M-extension unit
interface riscv_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            StartE;
  logic [2:0]      FunctE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] ResultM;

  modport master (
    output StartE, FunctE, SrcAE, SrcBE, FlushE,
    input  Busy, Done, ResultM
  );

  modport slave (
    input  StartE, FunctE, SrcAE, SrcBE, FlushE,
    output Busy, Done, ResultM
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// rtl/riscv_muldiv_unit.sv - RV32M/RV64M multiply (fixed latency) and restoring divide unit
module riscv_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input logic                 clk,
  input logic                 reset,
  riscv_muldiv_unit_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  localparam int CMAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
  localparam int CW   = $clog2(CMAX);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [1:0]      op_q, op_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // For MUL ops a_q/b_q hold raw operands; for DIV ops they hold magnitudes,
  // and a_q doubles as the quotient shift register.
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  assign a_ext = {{XLEN{(op_q[1] ^ op_q[0]) & a_q[XLEN-1]}}, a_q};
  assign b_ext = {{XLEN{(op_q == 2'b01) & b_q[XLEN-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  logic            start_ok;
  logic            div_signed;
  logic            a_neg, b_neg;
  logic [XLEN:0]   rem_shift, diff;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    op_d       = op_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    result_d   = result_q;
    div_signed = 1'b0;
    a_neg      = 1'b0;
    b_neg      = 1'b0;
    rem_shift  = {rem_q, a_q[XLEN-1]};
    diff       = rem_shift - {1'b0, b_q};
    start_ok   = bus.StartE && !bus.FlushE &&
                 ((state_q == S_IDLE) || (state_q == S_DONE));

    case (state_q)
      S_MUL: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
      end
      S_DIV: begin
        cnt_d = cnt_q - CW'(1);
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[1]) result_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
        else         result_d = qneg_q ? (~a_q + 1'b1) : a_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start_ok) begin
      op_d = bus.FunctE[1:0];
      if (!bus.FunctE[2]) begin
        a_d     = bus.SrcAE;
        b_d     = bus.SrcBE;
        cnt_d   = CW'(MUL_STAGES - 1);
        state_d = S_MUL;
      end else begin
        div_signed = !bus.FunctE[0];
        a_neg      = div_signed & bus.SrcAE[XLEN-1];
        b_neg      = div_signed & bus.SrcBE[XLEN-1];
        a_d        = a_neg ? (~bus.SrcAE + 1'b1) : bus.SrcAE;
        b_d        = b_neg ? (~bus.SrcBE + 1'b1) : bus.SrcBE;
        rem_d      = '0;
        qneg_d     = a_neg ^ b_neg;
        rneg_d     = a_neg;
        // Divide-by-zero and signed overflow resolve immediately without iterating.
        if (bus.SrcBE == '0) begin
          result_d = bus.FunctE[1] ? bus.SrcAE : '1;
          state_d  = S_DONE;
        end else if (div_signed && (bus.SrcAE == SMIN) && (bus.SrcBE == '1)) begin
          result_d = bus.FunctE[1] ? '0 : bus.SrcAE;
          state_d  = S_DONE;
        end else begin
          cnt_d   = CW'(XLEN - 1);
          state_d = S_DIV;
        end
      end
    end

    if (bus.FlushE) state_d = S_IDLE;

    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.ResultM = result_q;

endmodule
